// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel switch debouncer.
//   Each raw input is synchronised (2 FF), sampled on a shared prescaler
//   tick, and committed to a new level only after DEBOUNCE_LIMIT consecutive
//   differing ticks. Every channel reports its clean level plus single-cycle
//   rise / fall / long-press hold pulses.
// Ports:
//   i_Clk      system clock (single clock domain)
//   i_Reset    synchronous active-high reset
//   i_Switch   [NUM_CH] raw asynchronous switch inputs
//   o_State    [NUM_CH] debounced levels
//   o_Rise     [NUM_CH] one-cycle pulse on committed 0->1
//   o_Fall     [NUM_CH] one-cycle pulse on committed 1->0
//   o_Hold     [NUM_CH] one-cycle pulse after HOLD_LIMIT ticks at 1
//   o_Changed  registered OR of all rise/fall pulses, aligned with them

// Per-channel debounce, edge and hold logic.
module debounce_ch #(
   parameter int   DEBOUNCE_LIMIT = 10,
   parameter int   HOLD_LIMIT     = 1000,
   parameter logic INIT_STATE     = 1'b0
) (
   input  logic i_Clk,
   input  logic i_Reset,
   input  logic i_Tick,
   input  logic i_Switch,
   output logic o_State,
   output logic o_Rise,
   output logic o_Fall,
   output logic o_Hold,
   output logic o_Rise_Next,
   output logic o_Fall_Next
);
   localparam int CW = $clog2(DEBOUNCE_LIMIT + 1);
   localparam int HW = (HOLD_LIMIT > 0) ? $clog2(HOLD_LIMIT + 1) : 1;
   localparam logic          HOLD_EN   = (HOLD_LIMIT != 0);
   localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_LIMIT - 1);
   localparam logic [HW-1:0] HOLD_LAST = HOLD_EN ? HW'(HOLD_LIMIT - 1) : '0;

   logic          sync_1, sync_2, state, fired;
   logic [CW-1:0] cnt;
   logic [HW-1:0] hold_cnt;
   logic          differ, commit, hold_hit;

   assign differ = (sync_2 != state);
   assign commit = i_Tick && differ && (cnt == CNT_LAST);
   // A committing fall takes priority, so hold never coincides with fall.
   assign hold_hit = HOLD_EN && i_Tick && state && !fired && !commit &&
                     (hold_cnt == HOLD_LAST);

   assign o_Rise_Next = commit && !state;
   assign o_Fall_Next = commit && state;
   assign o_State     = state;

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         sync_1   <= INIT_STATE;
         sync_2   <= INIT_STATE;
         state    <= INIT_STATE;
         cnt      <= '0;
         hold_cnt <= '0;
         fired    <= 1'b0;
         o_Rise   <= 1'b0;
         o_Fall   <= 1'b0;
         o_Hold   <= 1'b0;
      end else begin
         sync_1 <= i_Switch;
         sync_2 <= sync_1;
         o_Rise <= o_Rise_Next;
         o_Fall <= o_Fall_Next;
         o_Hold <= hold_hit;

         if (i_Tick) begin
            if (!differ) begin
               cnt <= '0;             // any bounce back restarts the count
            end else if (commit) begin
               state <= sync_2;
               cnt   <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end

         // The committing tick itself never counts toward hold; counting
         // starts on the tick after state reads 1.
         if (!state || commit) begin
            hold_cnt <= '0;
            fired    <= 1'b0;
         end else if (HOLD_EN && i_Tick && !fired) begin
            hold_cnt <= hold_cnt + HW'(1);
            if (hold_hit) fired <= 1'b1;
         end
      end
   end
endmodule

module debounce_bank #(
   parameter int   NUM_CH         = 4,
   parameter int   TICK_DIV       = 25000,
   parameter int   DEBOUNCE_LIMIT = 10,
   parameter int   HOLD_LIMIT     = 1000,
   parameter logic INIT_STATE     = 1'b0
) (
   input  logic              i_Clk,
   input  logic              i_Reset,
   input  logic [NUM_CH-1:0] i_Switch,
   output logic [NUM_CH-1:0] o_State,
   output logic [NUM_CH-1:0] o_Rise,
   output logic [NUM_CH-1:0] o_Fall,
   output logic [NUM_CH-1:0] o_Hold,
   output logic              o_Changed
);
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] DIV_LAST = TW'(TICK_DIV - 1);

   logic [TW-1:0]     div_cnt;
   logic              tick;
   logic [NUM_CH-1:0] rise_next, fall_next;

   // With TICK_DIV=1 the counter sits at 0 and tick is permanently high.
   assign tick = (div_cnt == DIV_LAST);

   always_ff @(posedge i_Clk) begin
      if (i_Reset)   div_cnt <= '0;
      else if (tick) div_cnt <= '0;
      else           div_cnt <= div_cnt + TW'(1);
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      debounce_ch #(
         .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
         .HOLD_LIMIT     (HOLD_LIMIT),
         .INIT_STATE     (INIT_STATE)
      ) u_ch (
         .i_Clk       (i_Clk),
         .i_Reset     (i_Reset),
         .i_Tick      (tick),
         .i_Switch    (i_Switch[g]),
         .o_State     (o_State[g]),
         .o_Rise      (o_Rise[g]),
         .o_Fall      (o_Fall[g]),
         .o_Hold      (o_Hold[g]),
         .o_Rise_Next (rise_next[g]),
         .o_Fall_Next (fall_next[g])
      );
   end

   // Built from the next-cycle pulse terms so it lands with o_Rise/o_Fall.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) o_Changed <= 1'b0;
      else         o_Changed <= |(rise_next | fall_next);
   end
endmodule

// File: tb/tb_debounce_bank.sv
module tb_debounce_bank;
   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] sw, sw_b;
   logic [1:0] st_a, rise_a, fall_a, hold_a;
   logic [1:0] st_b, rise_b, fall_b, hold_b;
   logic       chg_a, chg_b;
   int         cyc = 0;
   int         n_chk = 0;
   int         n_err = 0;

   typedef struct {
      int         cyc;
      logic [1:0] r;
      logic [1:0] f;
      logic [1:0] h;
   } ev_t;
   ev_t q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   debounce_bank #(.NUM_CH(2), .TICK_DIV(1), .DEBOUNCE_LIMIT(4),
                   .HOLD_LIMIT(8), .INIT_STATE(1'b0)) u_dut_a (
      .i_Clk(clk), .i_Reset(rst), .i_Switch(sw), .o_State(st_a),
      .o_Rise(rise_a), .o_Fall(fall_a), .o_Hold(hold_a), .o_Changed(chg_a));

   debounce_bank #(.NUM_CH(2), .TICK_DIV(4), .DEBOUNCE_LIMIT(4),
                   .HOLD_LIMIT(8), .INIT_STATE(1'b0)) u_dut_b (
      .i_Clk(clk), .i_Reset(rst), .i_Switch(sw_b), .o_State(st_b),
      .o_Rise(rise_b), .o_Fall(fall_b), .o_Hold(hold_b), .o_Changed(chg_b));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic push(input int c, input logic [1:0] r, input logic [1:0] f, input logic [1:0] h);
      ev_t e;
      e.cyc = c; e.r = r; e.f = f; e.h = h;
      q.push_back(e);
   endtask

   task automatic at(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Scoreboard monitor for the TICK_DIV=1 instance: every pulse must match
   // the next expected event, and a due event that never shows is a miss.
   always @(negedge clk) begin : mon
      ev_t e;
      chk("chg", {31'b0, chg_a}, {31'b0, |(rise_a | fall_a)});
      if ((rise_a | fall_a | hold_a) != 2'b00) begin
         if (q.size() == 0) begin
            chk("unexp", {26'b0, rise_a, fall_a, hold_a}, 32'd0);
         end else begin
            e = q.pop_front();
            chk("ev_cyc", cyc, e.cyc);
            chk("ev_pulse", {26'b0, rise_a, fall_a, hold_a}, {26'b0, e.r, e.f, e.h});
         end
      end else if (q.size() != 0 && q[0].cyc <= cyc) begin
         e = q.pop_front();
         chk("miss", {26'b0, rise_a, fall_a, hold_a}, {26'b0, e.r, e.f, e.h});
      end
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, r, lat;
      logic [3:0] bp;

      // 1. reset with inputs high
      rst = 1'b1; sw = 2'b11; sw_b = 2'b00;
      repeat (3) begin
         @(negedge clk);
         chk("rst_out", {23'b0, st_a, rise_a, fall_a, hold_a, chg_a}, 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      chk("rel_out", {23'b0, st_a, rise_a, fall_a, hold_a, chg_a}, 32'd0);
      sw = 2'b00;
      n = cyc;
      at(n + 10);
      chk("idle_st", st_a, 2'b00);

      // 2. clean rise on ch0, then release
      n = cyc;
      sw = 2'b01;
      push(n + 6, 2'b01, 2'b00, 2'b00);
      at(n + 5);
      chk("rise_pre", st_a, 2'b00);
      at(n + 6);
      chk("rise_st", st_a, 2'b01);
      at(n + 7);
      chk("rise_1cyc", rise_a, 2'b00);
      sw = 2'b00;
      push(n + 13, 2'b00, 2'b01, 2'b00);
      at(n + 16);
      chk("fall_st", st_a, 2'b00);

      // 3. bounce: 1,1,1,0 then steady 1; first run is one tick short
      n = cyc;
      bp = 4'b0111;
      for (int j = 0; j < 4; j++) begin
         sw[0] = bp[j];
         @(negedge clk);
      end
      sw[0] = 1'b1;
      push(n + 10, 2'b01, 2'b00, 2'b00);
      push(n + 18, 2'b00, 2'b00, 2'b01);
      at(n + 9);
      chk("bnc_nocommit", st_a, 2'b00);
      at(n + 20);
      chk("bnc_st", st_a, 2'b01);
      sw[0] = 1'b0;
      push(n + 26, 2'b00, 2'b01, 2'b00);
      at(n + 30);
      chk("bnc_rel", st_a, 2'b00);

      // 4. hold on ch1, release, press again
      n = cyc;
      sw[1] = 1'b1;
      push(n + 6,  2'b10, 2'b00, 2'b00);
      push(n + 14, 2'b00, 2'b00, 2'b10);
      at(n + 30);
      chk("hold_st", st_a, 2'b10);
      sw[1] = 1'b0;
      push(n + 36, 2'b00, 2'b10, 2'b00);
      at(n + 40);
      sw[1] = 1'b1;
      push(n + 46, 2'b10, 2'b00, 2'b00);
      push(n + 54, 2'b00, 2'b00, 2'b10);
      at(n + 60);
      sw[1] = 1'b0;
      push(n + 66, 2'b00, 2'b10, 2'b00);
      at(n + 70);

      // 5. simultaneous rise; the fall lands on the tick that would have
      //    been the 8th hold tick, so no hold may appear
      n = cyc;
      sw = 2'b11;
      push(n + 6, 2'b11, 2'b00, 2'b00);
      at(n + 8);
      sw = 2'b00;
      push(n + 14, 2'b00, 2'b11, 2'b00);
      at(n + 20);
      chk("sim_st", st_a, 2'b00);

      // 5b. prescaled instance
      sw_b = 2'b11;
      lat = -1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (rise_b != 2'b00) begin
            lat = k;
            break;
         end
      end
      chk("b_lat_ok", {31'b0, (lat >= 15 && lat <= 18)}, 32'd1);
      chk("b_rise", rise_b, 2'b11);
      chk("b_chg", {31'b0, chg_b}, 32'd1);
      @(negedge clk);
      chk("b_st", st_b, 2'b11);

      // 6. reset just before ch0 would commit
      n = cyc;
      sw = 2'b01;
      at(n + 5);
      rst = 1'b1;
      at(n + 6);
      chk("mid_st", st_a, 2'b00);
      chk("b_rst", st_b, 2'b00);
      at(n + 7);
      rst = 1'b0;
      r = cyc;
      push(r + 6,  2'b01, 2'b00, 2'b00);
      push(r + 14, 2'b00, 2'b00, 2'b01);
      at(r + 5);
      chk("mid_pre", st_a, 2'b00);
      at(r + 20);
      chk("mid_st2", st_a, 2'b01);
      chk("sb_empty", q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised multi-channel switch debouncer with input synchronisation, a shared sampling prescaler, and per-channel event outputs (rise, fall, long-press hold). It sits between raw board inputs (keypad rows, door/window sensors, arm/disarm buttons) and the security-system control FSMs. It gives each channel a clean level plus single-cycle event pulses, so downstream logic never needs its own edge detectors.

## Interface
Parameters:
- NUM_CH, 4: number of independent channels.
- TICK_DIV, 25000: clock cycles per sample tick (1 ms at 25 MHz); 1 = sample every cycle.
- DEBOUNCE_LIMIT, 10: consecutive differing ticks required to commit a new level (≥1).
- HOLD_LIMIT, 1000: ticks a channel must stay at 1 before o_Hold fires; 0 disables hold.
- INIT_STATE, 1'b0: reset level of every channel.

Ports:
- i_Clk  in  1  system clock; the block is single-clock.
- i_Reset  in  1  reset, synchronous and active-high.
- i_Switch  in  NUM_CH  raw asynchronous switch inputs.
- o_State  out  NUM_CH  debounced levels.
- o_Rise  out  NUM_CH  one-cycle pulse when o_State[n] goes 0→1.
- o_Fall  out  NUM_CH  one-cycle pulse when o_State[n] goes 1→0.
- o_Hold  out  NUM_CH  one-cycle pulse when o_State[n] has been 1 for HOLD_LIMIT ticks.
- o_Changed  out  1  registered OR of all o_Rise and o_Fall bits, in the same cycle as those bits.

## Operation
- **Synchroniser.** Each i_Switch bit passes through a 2-FF synchroniser clocked every cycle. Both FFs reset to INIT_STATE.
- **Prescaler.** One shared counter runs 0..TICK_DIV-1. The tick is asserted in the cycle where the count is TICK_DIV-1, and the counter then wraps to 0. It resets to 0.
- **Per-channel debounce counter.** Width is $clog2(DEBOUNCE_LIMIT+1). Action is taken on a tick only:
  - If sync ≠ state and cnt == DEBOUNCE_LIMIT-1: state ← sync, cnt ← 0, and the rise or fall pulse is raised.
  - If sync ≠ state and cnt < DEBOUNCE_LIMIT-1: cnt ← cnt+1.
  - If sync == state: cnt ← 0. Any bounce back restarts the count.
  - Between ticks, counters and state hold.
- **Hold.** Each channel has a hold counter of width $clog2(HOLD_LIMIT+1) and a fired flag.
  - On each tick with state == 1 and fired == 0, hold_cnt increments.
  - When the increment reaches HOLD_LIMIT, o_Hold pulses and fired ← 1. The counter saturates, so o_Hold fires at most once per press.
  - State == 0 clears hold_cnt and fired. The tick committing a 1 does not count; counting starts on the following tick.
- **Channel independence.** Channels are fully independent, and any number may commit on the same tick.
- **Pulse relationships.** o_Rise and o_Fall are mutually exclusive per channel. o_Hold cannot coincide with o_Fall on the same channel.

## Timing
- **Reset values.** o_State = {NUM_CH{INIT_STATE}}. o_Rise, o_Fall, o_Hold and o_Changed are 0. All counters are 0 and the fired flags are 0. No pulses are emitted in the first cycle after reset release.
- **Reset mid-operation.** This is a synchronous clear of everything, including partial counts and in-progress holds.
- **Registered outputs.**
  - o_State and the event pulses are all registered.
  - o_Rise[n] or o_Fall[n] is high in exactly the first cycle that o_State[n] shows the new value, and low the next cycle.
- **Debounce latency, TICK_DIV=1.** Number the first clock edge that samples the new i_Switch value as edge 1. o_State updates on edge DEBOUNCE_LIMIT+2: two synchroniser edges, then DEBOUNCE_LIMIT compare edges.
- **Debounce latency, TICK_DIV=D.** Latency is between (DEBOUNCE_LIMIT-1)·D+3 and DEBOUNCE_LIMIT·D+2 cycles, depending on prescaler phase.
- **Hold latency.** o_Hold fires on the HOLD_LIMIT-th tick after the committing tick.
- **Boundary cases.**
  - DEBOUNCE_LIMIT=1 commits on the first differing tick.
  - An input that differs for exactly DEBOUNCE_LIMIT-1 ticks and then reverts never commits.
- **Counter widths.** Counters never exceed their limit, so there is no wrap-around.

## Test plan
Parameters for directed tests: NUM_CH=2, TICK_DIV=1, DEBOUNCE_LIMIT=4, HOLD_LIMIT=8, INIT_STATE=0.
1. **Reset.** Hold i_Reset for 3 cycles with i_Switch=2'b11, then release. Expect o_State=00 and all pulses 0 during reset and in the first cycle after release.
2. **Clean rise.** i_Switch[0] goes 0→1, sampled at edge 1. Expect o_State[0]=1 after edge 6, and o_Rise[0] and o_Changed high for that one cycle only. Channel 1 stays unchanged.
3. **Bounce.** i_Switch[0] sequence 1,1,1,0,1,1,1,1… (starting from state 0). Expect no commit for the first run. Expect commit 4 compare edges after the final stable 1 reaches the synchroniser output. o_Rise[0] pulses exactly once.
4. **Hold and release.** Hold ch1 at 1. Expect the commit at edge 6 and o_Hold[1] as a single pulse after edge 14, with no repeat while held. Then release. Expect o_Fall[1] 6 edges later. Press again and expect o_Hold[1] to fire again.
5. **Simultaneous and prescaled.** Drive both channels 0→1 on the same edge. Expect o_Rise=2'b11 in the same cycle with o_Changed=1. Repeat with TICK_DIV=4. Expect the commit within cycles 15..18.
6. **Reset mid-count.** Assert i_Reset when ch0 cnt=3 (after edge 5 of a rise). Expect no o_Rise and o_State[0]=0. After release with i_Switch[0] still 1, expect the full 6-edge latency again.
